// File: rtl/apb_pkg.sv
// Shared types and sizing helpers for the APB register-file completer.
package apb_pkg;

  typedef enum logic [1:0] {APB_IDLE, APB_ACCESS} apb_state_e;

  localparam logic APB_ERR_RESP = 1'b1;

  function automatic int unsigned strb_width(input int unsigned data_w);
    return data_w / 8;
  endfunction

  function automatic int unsigned idx_shift(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

  // A zero-wait build still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned wait_cycles);
    return (wait_cycles == 0) ? 1 : $clog2(wait_cycles + 1);
  endfunction

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB4 bus bundle between requester (master) and completer (slave).
interface apb_slave_regfile_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   PADDR;
  logic [DATA_W-1:0]   PWDATA;
  logic [DATA_W/8-1:0] PSTRB;
  logic                PWRITE;
  logic                PSEL;
  logic                PENABLE;
  logic [DATA_W-1:0]   PRDATA;
  logic                PREADY;
  logic                PSLVERR;

  modport master (
    output PADDR, PWDATA, PSTRB, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PWDATA, PSTRB, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_wait_timer.sv
// Loadable down-counter that times the wait states of one ACCESS phase.
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);
  localparam int unsigned CNT_W = cnt_width(WAIT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CNT_W'(WAIT_CYCLES);
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/apb_slave_regfile.sv
// APB4 register-file completer with wait states and error response.
// Byte strobes are honoured only when APB_PSTRB_EN is defined; otherwise writes are full-word.
//   state      | meaning
//   APB_IDLE   | waiting for a setup phase (PSEL=1, PENABLE=0)
//   APB_ACCESS | transfer captured; PREADY once the wait timer hits zero
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       NUM_REGS    = 16,
  parameter int unsigned       WAIT_CYCLES = 0,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic                         PCLK,
  input  logic                         PRESETn,
  apb_slave_regfile_if.slave           apb,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q
);
  localparam int unsigned STRB_W = strb_width(DATA_W);
  localparam int unsigned SHIFT  = idx_shift(DATA_W);
  localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  apb_state_e                 state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic                       write_q, write_d;
  logic                       err_q, err_d;
  logic [DATA_W-1:0]          wdata_q, wdata_d;
  logic [STRB_W-1:0]          strb_q, strb_d;
  logic [NUM_REGS*DATA_W-1:0] regs_q, regs_d;

  logic [ADDR_W-1:0] word_idx;
  logic              setup, access_hs, cnt_zero, complete, ready;

  assign setup     = apb.PSEL && !apb.PENABLE;
  assign access_hs = (state_q == APB_ACCESS) && apb.PSEL && apb.PENABLE;
  assign complete  = access_hs && cnt_zero;
  assign word_idx  = (apb.PADDR - BASE_ADDR) >> SHIFT;

`ifndef APB_PSTRB_EN
  logic unused_pstrb;
  assign unused_pstrb = ^apb.PSTRB;
`endif

  apb_wait_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait_timer (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .load  ((state_q == APB_IDLE) && setup),
    .dec   (access_hs && !cnt_zero),
    .zero  (cnt_zero)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    write_d = write_q;
    err_d   = err_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    regs_d  = regs_q;
    unique case (state_q)
      APB_IDLE: begin
        if (setup) begin
          state_d = APB_ACCESS;
          idx_d   = IDX_W'(word_idx);
          write_d = apb.PWRITE;
          wdata_d = apb.PWDATA;
`ifdef APB_PSTRB_EN
          strb_d  = apb.PSTRB;
`else
          strb_d  = '1;
`endif
          // BASE_ADDR is aligned, so low address bits alone decide alignment.
          err_d   = (apb.PADDR < BASE_ADDR)
                 || ((apb.PADDR & ADDR_W'(STRB_W - 1)) != '0)
                 || (word_idx >= ADDR_W'(NUM_REGS));
        end
      end
      APB_ACCESS: begin
        if (!apb.PSEL) begin
          state_d = APB_IDLE;
        end else if (complete) begin
          state_d = APB_IDLE;
          if (write_q && !err_q) begin
            for (int b = 0; b < STRB_W; b++) begin
              if (strb_q[b]) regs_d[int'(idx_q)*DATA_W + b*8 +: 8] = wdata_q[b*8 +: 8];
            end
          end
        end
      end
      default: state_d = APB_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= APB_IDLE;
      idx_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      regs_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      regs_q  <= regs_d;
    end
  end

  // Response is decoded purely from registered state: no input-to-output path.
  assign ready       = (state_q == APB_ACCESS) && cnt_zero;
  assign apb.PREADY  = ready;
  assign apb.PSLVERR = (ready && err_q) ? APB_ERR_RESP : 1'b0;
  assign apb.PRDATA  = (ready && !write_q && !err_q) ? regs_q[int'(idx_q)*DATA_W +: DATA_W] : '0;
  assign reg_q       = regs_q;
endmodule

// File: tb/tb_apb_slave_regfile.sv
// Randomized + directed bench for apb_slave_regfile: two instances (0 and 3 wait states)
// checked each cycle against an array-based model of the register file.
module tb_apb_slave_regfile;
  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam int          NR   = 16;
  localparam int          W0   = 0;
  localparam int          W1   = 3;
  localparam logic [31:0] BASE = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] m_addr = '0, m_wdata = '0;
  logic [3:0]  m_strb = '0;
  logic        m_write = 1'b0, m_psel = 1'b0, m_pen = 1'b0;
  int          m_dut = 0;

  apb_slave_regfile_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
  apb_slave_regfile_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

  assign bus0.PADDR   = m_addr;
  assign bus0.PWDATA  = m_wdata;
  assign bus0.PSTRB   = m_strb;
  assign bus0.PWRITE  = m_write;
  assign bus0.PSEL    = m_psel && (m_dut == 0);
  assign bus0.PENABLE = m_pen;
  assign bus1.PADDR   = m_addr;
  assign bus1.PWDATA  = m_wdata;
  assign bus1.PSTRB   = m_strb;
  assign bus1.PWRITE  = m_write;
  assign bus1.PSEL    = m_psel && (m_dut == 1);
  assign bus1.PENABLE = m_pen;

  logic [NR*DW-1:0] regq0, regq1;

  apb_slave_regfile #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .WAIT_CYCLES(W0), .BASE_ADDR(BASE))
    u_dut0 (.PCLK(clk), .PRESETn(rst_n), .apb(bus0), .reg_q(regq0));
  apb_slave_regfile #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .WAIT_CYCLES(W1), .BASE_ADDR(BASE))
    u_dut1 (.PCLK(clk), .PRESETn(rst_n), .apb(bus1), .reg_q(regq1));

  // Model state and per-cycle expectations.
  logic [31:0] mdl [2][NR];
  logic        exp_rdy [2] = '{1'b0, 1'b0};
  logic        exp_err [2] = '{1'b0, 1'b0};
  logic [31:0] exp_rd  [2] = '{32'h0, 32'h0};
  logic        chk_rd  [2] = '{1'b1, 1'b1};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_regs(input string name, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic dec_err(input logic [31:0] a);
    return (a < BASE) || (((a - BASE) % 4) != 0) || (((a - BASE) / 4) >= 32'(NR));
  endfunction

  function automatic int dec_idx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [NR*DW-1:0] pack(input int d);
    logic [NR*DW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = mdl[d][i];
    return v;
  endfunction

  task automatic clr_exp();
    for (int d = 0; d < 2; d++) begin
      exp_rdy[d] = 1'b0;
      exp_err[d] = 1'b0;
      exp_rd[d]  = '0;
      chk_rd[d]  = 1'b1;
    end
  endtask

  // Every negedge: both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("pready0", 32'(bus0.PREADY), 32'(exp_rdy[0]));
      chk("pslverr0", 32'(bus0.PSLVERR), 32'(exp_err[0]));
      if (chk_rd[0]) chk("prdata0", bus0.PRDATA, exp_rd[0]);
      chk_regs("reg_q0", regq0, pack(0));
      chk("pready1", 32'(bus1.PREADY), 32'(exp_rdy[1]));
      chk("pslverr1", 32'(bus1.PSLVERR), 32'(exp_err[1]));
      if (chk_rd[1]) chk("prdata1", bus1.PRDATA, exp_rd[1]);
      chk_regs("reg_q1", regq1, pack(1));
    end
  end

  // Entered and left at posedge+1.
  task automatic xfer(input int d, input logic [31:0] a, input logic wr, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rd, output logic er, output int ncyc);
    int  wc, k;
    logic done;
    wc = (d == 0) ? W0 : W1;
    rd = '0; er = 1'b0; ncyc = -1;
    clr_exp();
    m_dut = d; m_psel = 1'b1; m_pen = 1'b0;
    m_addr = a; m_write = wr; m_wdata = wd; m_strb = st;
    @(posedge clk); #1;
    m_pen = 1'b1;
    done = 1'b0;
    k = 0;
    while (!done && k < 20) begin
      exp_rdy[d] = (k == wc);
      exp_err[d] = exp_rdy[d] && dec_err(a);
      chk_rd[d]  = !exp_rdy[d] || !wr;
      exp_rd[d]  = '0;
      if (exp_rdy[d] && !wr && !dec_err(a)) exp_rd[d] = mdl[d][dec_idx(a)];
      @(negedge clk);
      if ((d == 0) ? bus0.PREADY : bus1.PREADY) begin
        done = 1'b1;
        ncyc = k;
        rd   = (d == 0) ? bus0.PRDATA : bus1.PRDATA;
        er   = (d == 0) ? bus0.PSLVERR : bus1.PSLVERR;
      end
      @(posedge clk); #1;
      k++;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL xfer_timeout: no PREADY after %0d cycles, required within %0d", k, wc + 1);
    end else if (wr && !dec_err(a)) begin
`ifdef APB_PSTRB_EN
      for (int b = 0; b < 4; b++) if (st[b]) mdl[d][dec_idx(a)][b*8 +: 8] = wd[b*8 +: 8];
`else
      mdl[d][dec_idx(a)] = wd;
`endif
    end
    clr_exp();
  endtask

  task automatic idle(input int n);
    m_psel = 1'b0;
    m_pen  = 1'b0;
    clr_exp();
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  logic [31:0] rd, ra;
  logic        er;
  int          nc;
  logic [31:0] exp_strb;

  initial begin
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NR; i++) mdl[d][i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pready", 32'(bus1.PREADY), 32'h0);
    chk_regs("reset_regq", regq1, '0);
    rst_n = 1'b1;
    idle(1);

    // 3 wait states: ready on the 4th ACCESS cycle, reset data reads as 0.
    xfer(1, BASE, 1'b0, '0, '0, rd, er, nc);
    chk("t2_wait_cycles", 32'(nc), 32'd3);
    chk("t2_rdata", rd, 32'h0);
    idle(1);

    // Zero-wait write then read.
    xfer(0, BASE + 32'h4, 1'b1, 32'hDEADBEEF, 4'hF, rd, er, nc);
    chk("t1_wr_cycles", 32'(nc), 32'd0);
    chk("t1_wr_err", 32'(er), 32'h0);
    chk("t1_regq", regq0[63:32], 32'hDEADBEEF);
    idle(1);
    xfer(0, BASE + 32'h4, 1'b0, '0, '0, rd, er, nc);
    chk("t1_rdata", rd, 32'hDEADBEEF);
    chk("t1_rd_err", 32'(er), 32'h0);
    idle(1);

    // Byte strobes.
    xfer(0, BASE + 32'hC, 1'b1, 32'hFFFFFFFF, 4'hF, rd, er, nc);
    xfer(0, BASE + 32'hC, 1'b1, 32'h12345678, 4'b0101, rd, er, nc);
    xfer(0, BASE + 32'hC, 1'b0, '0, '0, rd, er, nc);
`ifdef APB_PSTRB_EN
    exp_strb = 32'hFF34FF78;
`else
    exp_strb = 32'h12345678;
`endif
    chk("t3_strb_rdata", rd, exp_strb);
    idle(2);

    // Error responses on both instances.
    for (int d = 0; d < 2; d++) begin
      xfer(d, BASE + 32'h40, 1'b1, 32'hCAFEF00D, 4'hF, rd, er, nc);
      chk("t4_err_range", 32'(er), 32'h1);
      xfer(d, BASE + 32'h2, 1'b1, 32'hCAFEF00D, 4'hF, rd, er, nc);
      chk("t4_err_unaligned", 32'(er), 32'h1);
      xfer(d, BASE - 32'h4, 1'b1, 32'hCAFEF00D, 4'hF, rd, er, nc);
      chk("t4_err_below", 32'(er), 32'h1);
      xfer(d, BASE + 32'h40, 1'b0, '0, '0, rd, er, nc);
      chk("t4_rd_err", 32'(er), 32'h1);
      chk("t4_rd_data", rd, 32'h0);
      idle(1);
    end
    chk("t4_regq_intact", regq0[63:32], 32'hDEADBEEF);

    // Back-to-back write then read, PSEL held.
    for (int d = 0; d < 2; d++) begin
      xfer(d, BASE + 32'h8, 1'b1, 32'h0BAD_CAB0 + 32'(d), 4'hF, rd, er, nc);
      xfer(d, BASE + 32'h8, 1'b0, '0, '0, rd, er, nc);
      chk("t5_b2b_rdata", rd, 32'h0BAD_CAB0 + 32'(d));
    end
    idle(1);

    // Protocol abort: PSEL drops during the wait, nothing is written.
    m_dut = 1; m_psel = 1'b1; m_pen = 1'b0;
    m_addr = BASE + 32'h8; m_write = 1'b1; m_wdata = 32'h5555AAAA; m_strb = 4'hF;
    @(posedge clk); #1;
    m_pen = 1'b1;
    @(posedge clk); #1;
    idle(2);
    xfer(1, BASE + 32'h8, 1'b0, '0, '0, rd, er, nc);
    chk("abort_nowrite", rd, 32'h0BAD_CAB1);
    chk("abort_wait_cycles", 32'(nc), 32'd3);
    idle(1);

    // Randomized traffic.
    for (int t = 0; t < 300; t++) begin
      int d, sel;
      d = int'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 11));
      if (sel == 0)      ra = BASE - 32'h4 * $urandom_range(1, 8);
      else if (sel == 1) ra = BASE + 32'h4 * $urandom_range(NR, NR + 4);
      else if (sel == 2) ra = BASE + 32'h4 * $urandom_range(0, NR - 1) + $urandom_range(1, 3);
      else               ra = BASE + 32'h4 * $urandom_range(0, NR - 1);
      xfer(d, ra, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), rd, er, nc);
      chk("rand_err", 32'(er), 32'(dec_err(ra)));
      if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 2)));
    end
    idle(1);

    // Reset in the middle of a waited write.
    m_dut = 1; m_psel = 1'b1; m_pen = 1'b0;
    m_addr = BASE + 32'h10; m_write = 1'b1; m_wdata = 32'hA5A5A5A5; m_strb = 4'hF;
    @(posedge clk); #1;
    m_pen = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    m_psel = 1'b0; m_pen = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NR; i++) mdl[d][i] = '0;
    clr_exp();
    #1;
    chk_regs("rst_regq1", regq1, '0);
    chk_regs("rst_regq0", regq0, '0);
    chk("rst_pready", 32'(bus1.PREADY), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    xfer(1, BASE + 32'h10, 1'b0, '0, '0, rd, er, nc);
    chk("rst_lost_write", rd, 32'h0);
    xfer(0, BASE + 32'h4, 1'b0, '0, '0, rd, er, nc);
    chk("rst_cleared", rd, 32'h0);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
